// File: rtl/btn_conditioner.sv
// Five-channel pushbutton conditioner: synchronize, debounce, press strobe,
// and per-button auto-repeat for the buttons selected by REPEAT_MASK.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000,
  parameter logic [4:0]  REPEAT_MASK  = 5'b00011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse
);

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned MAX_DR  = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
  localparam int unsigned MAX_CYC = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RPT  = 2'd2;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_pulse;
  logic [NUM_BTN-1:0] w_level_nxt;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_rpt_due;
  logic [NUM_BTN-1:0] w_pulse_nxt;

  // Two-flop synchronizer; r_sync2 is the only view of the raw inputs downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic             w_lvl_nxt;

    // Accept a new level once it has differed for DEBOUNCE_CYC full cycles.
    always_comb begin
      w_dcnt_nxt = '0;
      w_lvl_nxt  = r_level[gi];
      if (r_sync2[gi] != r_level[gi]) begin
        if (r_dcnt == CNT_W'(DEBOUNCE_CYC)) begin
          w_lvl_nxt = r_sync2[gi];
        end else begin
          w_dcnt_nxt = r_dcnt + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dcnt      <= '0;
        r_level[gi] <= 1'b0;
      end else begin
        r_dcnt      <= w_dcnt_nxt;
        r_level[gi] <= w_lvl_nxt;
      end
    end

    assign w_level_nxt[gi] = w_lvl_nxt;
    assign w_rise[gi]      = w_lvl_nxt & ~r_level[gi];

    if (REPEAT_MASK[gi]) begin : g_rpt
      logic [1:0]       r_state;
      logic [1:0]       w_state_nxt;
      logic [CNT_W-1:0] r_rcnt;
      logic [CNT_W-1:0] w_rcnt_nxt;
      logic             w_due;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_IDLE;
          r_rcnt  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_rcnt  <= w_rcnt_nxt;
        end
      end

      // A falling level overrides every state and swallows a repeat due on that edge.
      always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_due       = 1'b0;
        case (r_state)
          ST_IDLE: begin
            w_rcnt_nxt = '0;
            if (w_rise[gi]) begin
              w_state_nxt = ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (r_rcnt == CNT_W'(REPEAT_DELAY - 1)) begin
              w_due       = 1'b1;
              w_rcnt_nxt  = '0;
              w_state_nxt = ST_RPT;
            end else begin
              w_rcnt_nxt = r_rcnt + CNT_W'(1);
            end
          end
          ST_RPT: begin
            if (r_rcnt == CNT_W'(REPEAT_RATE - 1)) begin
              w_due      = 1'b1;
              w_rcnt_nxt = '0;
            end else begin
              w_rcnt_nxt = r_rcnt + CNT_W'(1);
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_rcnt_nxt  = '0;
          end
        endcase
        if (!w_lvl_nxt) begin
          w_state_nxt = ST_IDLE;
          w_rcnt_nxt  = '0;
          w_due       = 1'b0;
        end
      end

      assign w_rpt_due[gi] = w_due;
    end else begin : g_norpt
      assign w_rpt_due[gi] = 1'b0;
    end
  end

  assign w_pulse_nxt = w_rise | w_rpt_due;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_pulse_nxt;
    end
  end

  assign btn_level = r_level;
  assign btn_pulse = r_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random stimulus, all
// checked against a window/age-based reference model of the button rules.
module tb_btn_conditioner;

  localparam int unsigned D    = 4;
  localparam int unsigned RD   = 10;
  localparam int unsigned RR   = 3;
  localparam logic [4:0]  MASK = 5'b00011;
  localparam int          HN   = D + 3;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;

  int checks;
  int failures;

  // Reference model state: raw sample history (index 0 = this edge), expected outputs.
  logic [4:0] hist [HN];
  logic [4:0] exp_level;
  logic [4:0] exp_pulse;
  int         t;
  int         rise_t [5];

  btn_conditioner #(
    .DEBOUNCE_CYC(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .REPEAT_MASK (MASK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int i = 0; i < HN; i++) hist[i] = '0;
    exp_level = '0;
    exp_pulse = '0;
    t = -1;
    for (int b = 0; b < 5; b++) rise_t[b] = 0;
  endtask

  // Level flips when the D+1 synchronized samples seen up to this edge all
  // hold the opposite value; repeats follow from the age of the press.
  task automatic model_edge(input logic [4:0] raw);
    t++;
    for (int j = HN - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = raw;
    exp_pulse = '0;
    for (int b = 0; b < 5; b++) begin
      logic want;
      logic stable;
      int   k;
      want   = ~exp_level[b];
      stable = 1'b1;
      for (int j = 2; j <= 2 + int'(D); j++) begin
        if (hist[j][b] != want) stable = 1'b0;
      end
      if (stable) begin
        exp_level[b] = want;
        if (want) begin
          rise_t[b]    = t;
          exp_pulse[b] = 1'b1;
        end
      end else if (exp_level[b] && MASK[b]) begin
        k = t - rise_t[b];
        if (k == int'(RD) || (k > int'(RD) && ((k - int'(RD)) % int'(RR)) == 0))
          exp_pulse[b] = 1'b1;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [4:0] raw);
    btn_raw = raw;
    @(posedge clk);
    model_edge(raw);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [4:0] raw);
    rst_n   = 1'b0;
    btn_raw = raw;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      btn_raw = 5'($urandom);
      @(negedge clk);
    end
    checks++;
    if (btn_level !== 5'b0) begin
      failures++;
      $display("FAIL reset_level got=%b exp=%b", btn_level, 5'b0);
    end
    checks++;
    if (btn_pulse !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulse got=%b exp=%b", btn_pulse, 5'b0);
    end
  endtask

  task automatic test_clean_press();
    logic e;
    do_reset(5'b0);
    for (int i = 0; i <= 30; i++) begin
      step(5'b00001);
      e = (t == 6) || (t == 16) || (t > 16 && ((t - 16) % 3) == 0);
      checks++;
      if (btn_pulse !== exp_pulse || btn_pulse[0] !== e) begin
        failures++;
        $display("FAIL clean_pulse t=%0d got=%b model=%b up_exp=%b", t, btn_pulse, exp_pulse, e);
      end
      checks++;
      if (btn_level !== exp_level || btn_level[0] !== (t >= 6)) begin
        failures++;
        $display("FAIL clean_level t=%0d got=%b model=%b", t, btn_level, exp_level);
      end
    end
  endtask

  task automatic test_bounce();
    int npulse;
    logic [4:0] raw;
    do_reset(5'b0);
    npulse = 0;
    for (int i = 0; i <= 30; i++) begin
      raw = (i < 4) ? ((i % 2 == 0) ? 5'b10000 : 5'b00000) : 5'b10000;
      step(raw);
      if (btn_pulse[4]) npulse++;
      checks++;
      if (btn_pulse !== exp_pulse || btn_pulse[4] !== (t == 10)) begin
        failures++;
        $display("FAIL bounce_pulse t=%0d got=%b model=%b", t, btn_pulse, exp_pulse);
      end
      checks++;
      if (btn_level !== exp_level) begin
        failures++;
        $display("FAIL bounce_level t=%0d got=%b model=%b", t, btn_level, exp_level);
      end
    end
    checks++;
    if (npulse != 1) begin
      failures++;
      $display("FAIL bounce_count got=%0d exp=1", npulse);
    end
  endtask

  task automatic test_release_mid_repeat();
    logic [4:0] raw;
    do_reset(5'b0);
    for (int i = 0; i <= 36; i++) begin
      raw = (i <= 12 || i >= 26) ? 5'b00010 : 5'b00000;
      step(raw);
      checks++;
      if (btn_pulse !== exp_pulse) begin
        failures++;
        $display("FAIL release_pulse t=%0d got=%b model=%b", t, btn_pulse, exp_pulse);
      end
      checks++;
      if (btn_level !== exp_level) begin
        failures++;
        $display("FAIL release_level t=%0d got=%b model=%b", t, btn_level, exp_level);
      end
      if (t == 19) begin
        checks++;
        if (btn_pulse[1] !== 1'b0 || btn_level[1] !== 1'b0) begin
          failures++;
          $display("FAIL release_due_edge pulse=%b level=%b exp=0/0", btn_pulse[1], btn_level[1]);
        end
      end
      if (t == 16 || t == 32) begin
        checks++;
        if (btn_pulse !== 5'b00010) begin
          failures++;
          $display("FAIL release_expected_pulse t=%0d got=%b exp=00010", t, btn_pulse);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int npulse;
    do_reset(5'b0);
    npulse = 0;
    for (int i = 0; i <= 25; i++) begin
      step(5'b01100);
      if (btn_pulse != 5'b0) npulse++;
      checks++;
      if (btn_pulse !== exp_pulse || btn_pulse !== ((t == 6) ? 5'b01100 : 5'b00000)) begin
        failures++;
        $display("FAIL simul_pulse t=%0d got=%b model=%b", t, btn_pulse, exp_pulse);
      end
    end
    checks++;
    if (npulse != 1 || btn_level !== 5'b01100) begin
      failures++;
      $display("FAIL simul_summary pulses=%0d level=%b exp=1/01100", npulse, btn_level);
    end
  endtask

  task automatic test_reset_mid_repeat();
    do_reset(5'b0);
    for (int i = 0; i <= 19; i++) step(5'b00001);
    checks++;
    if (btn_pulse !== 5'b00001 || exp_pulse !== 5'b00001) begin
      failures++;
      $display("FAIL pre_reset_pulse got=%b model=%b exp=00001", btn_pulse, exp_pulse);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
      failures++;
      $display("FAIL async_reset level=%b pulse=%b exp=0/0", btn_level, btn_pulse);
    end
    @(negedge clk);
    do_reset(5'b00001);
    for (int i = 0; i <= 20; i++) begin
      step(5'b00001);
      checks++;
      if (btn_pulse !== exp_pulse || btn_pulse[0] !== (t == 6 || t == 16 || t == 19)) begin
        failures++;
        $display("FAIL post_reset_pulse t=%0d got=%b model=%b", t, btn_pulse, exp_pulse);
      end
      checks++;
      if (btn_level !== exp_level) begin
        failures++;
        $display("FAIL post_reset_level t=%0d got=%b model=%b", t, btn_level, exp_level);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] raw;
    logic [4:0] prev;
    do_reset(5'b0);
    raw  = '0;
    prev = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 11) == 0) raw[b] = ~raw[b];
      end
      step(raw);
      checks++;
      if (btn_level !== exp_level) begin
        failures++;
        $display("FAIL rand_level t=%0d got=%b model=%b", t, btn_level, exp_level);
      end
      checks++;
      if (btn_pulse !== exp_pulse) begin
        failures++;
        $display("FAIL rand_pulse t=%0d got=%b model=%b", t, btn_pulse, exp_pulse);
      end
      checks++;
      if ((btn_pulse & prev) !== 5'b0) begin
        failures++;
        $display("FAIL rand_consecutive t=%0d got=%b prev=%b exp_overlap=00000", t, btn_pulse, prev);
      end
      prev = btn_pulse;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    btn_raw  = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_mid_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
